cpu_trace_capture: RTL

Parametrised execution-trace capture unit that sits beside the `ARM` core in simulation and FPGA builds. It samples the core's `pc`/`instruction` pair on each committed cycle into an on-chip buffer and detects a halt, i.e. the core spinning on one PC. After capture stops, it replays the buffer oldest-first over a pop handshake. It replaces free-running clock/reset benches that only expose the live `pc`/`instruction` wires, and it adds storage, halt detection and controlled readout.

---
 rtl/cpu_trace_capture.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_trace_capture.sv
// cpu_trace_capture: samples committed pc/instruction pairs into an on-chip
// buffer, detects a halt (core spinning on one PC), and replays the buffer
// oldest-first over a pop handshake once capture has stopped.
//
// Optional feature macro: TRACE_WRAP_EN
//   defined   -> the buffer is a ring; a full buffer overwrites its oldest entry
//                and capture continues until halt or stop.
//   undefined -> capture ends when the buffer fills.
//
// Readout handshake: rd_req is a request, not a ready. It is honoured only in
// DONE with count > 0 and never when arm is high in the same cycle. An honoured
// request at edge N yields rd_valid = 1 with rd_pc/rd_instr for exactly the one
// cycle after edge N. Requests may be held high to pop every cycle.
// The FSM state is visible on the state output (00 IDLE, 01 CAPTURE, 10 DONE).
module cpu_trace_capture #(
    parameter int WORD_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int STALL_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arm,
    input  logic                    stop,
    input  logic                    valid_in,
    input  logic [WORD_WIDTH-1:0]   pc_in,
    input  logic [WORD_WIDTH-1:0]   instr_in,
    input  logic                    rd_req,
    output logic                    rd_valid,
    output logic [WORD_WIDTH-1:0]   rd_pc,
    output logic [WORD_WIDTH-1:0]   rd_instr,
    output logic [$clog2(DEPTH):0]  count,
    output logic [1:0]              state,
    output logic                    halted,
    output logic                    overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_DONE    = 2'b10
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    logic [WORD_WIDTH-1:0] pc_mem    [DEPTH];
    logic [WORD_WIDTH-1:0] instr_mem [DEPTH];

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [WORD_WIDTH-1:0] prev_pc;
    logic                  have_prev;
    logic [SW-1:0]         stall_cnt;

    logic                  in_capture;
    logic                  full;
    logic                  arm_ok;
    logic                  cap_write;
    logic                  cap_drop;
    logic                  wrap_write;
    logic                  fill_done;
    logic [SW-1:0]         stall_next;
    logic                  halt_hit;
    logic                  pop;

    assign state = cur_state;

    // Capture/readout qualifiers and stall-counter lookahead for this cycle.
    always_comb begin
        in_capture = (cur_state == ST_CAPTURE);
        full       = (count == CW'(DEPTH));
        arm_ok     = arm && (cur_state != ST_CAPTURE);
`ifdef TRACE_WRAP_EN
        cap_write  = in_capture && valid_in;
        cap_drop   = 1'b0;
        wrap_write = cap_write && full;
        fill_done  = 1'b0;
`else
        cap_write  = in_capture && valid_in && !full;
        cap_drop   = in_capture && valid_in && full;
        wrap_write = 1'b0;
        fill_done  = cap_write && (count == CW'(DEPTH - 1));
`endif
        // The first sample of a capture has no predecessor and always starts a run of 1.
        stall_next = SW'(1);
        if (have_prev && (pc_in == prev_pc)) begin
            stall_next = stall_cnt + 1'b1;
        end
        halt_hit = cap_write && (stall_next == SW'(STALL_LIMIT));
        pop      = (cur_state == ST_DONE) && rd_req && (count != '0) && !arm;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic: arm starts a capture, stop/halt/fill end it.
    always_comb begin
        nxt_state = cur_state;
        unique case (cur_state)
            ST_IDLE: begin
                if (arm) nxt_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
`ifdef TRACE_WRAP_EN
                if (stop || halt_hit) nxt_state = ST_DONE;
`else
                if (stop || halt_hit || fill_done || full) nxt_state = ST_DONE;
`endif
            end
            ST_DONE: begin
                if (arm) nxt_state = ST_CAPTURE;
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Buffer storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (cap_write) begin
            pc_mem[wr_ptr]    <= pc_in;
            instr_mem[wr_ptr] <= instr_in;
        end
    end

    // Pointers, occupancy, halt detection, flags and the registered pop output.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            prev_pc   <= '0;
            have_prev <= 1'b0;
            stall_cnt <= '0;
            halted    <= 1'b0;
            overflow  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_pc     <= '0;
            rd_instr  <= '0;
        end else begin
            rd_valid <= 1'b0;
            if (arm_ok) begin
                // A new capture starts from an empty buffer with clean flags.
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                have_prev <= 1'b0;
                stall_cnt <= '0;
                halted    <= 1'b0;
                overflow  <= 1'b0;
            end else begin
                if (cap_write) begin
                    wr_ptr    <= wr_ptr + 1'b1;
                    prev_pc   <= pc_in;
                    have_prev <= 1'b1;
                    stall_cnt <= stall_next;
                    if (wrap_write) begin
                        // Ring is full: the oldest entry is overwritten, so the
                        // read pointer moves past it and occupancy stays at DEPTH.
                        rd_ptr   <= rd_ptr + 1'b1;
                        overflow <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                if (halt_hit) begin
                    halted <= 1'b1;
                end
                if (cap_drop) begin
                    overflow <= 1'b1;
                end
                if (pop) begin
                    rd_valid <= 1'b1;
                    rd_pc    <= pc_mem[rd_ptr];
                    rd_instr <= instr_mem[rd_ptr];
                    rd_ptr   <= rd_ptr + 1'b1;
                    count    <= count - 1'b1;
                end
            end
        end
    end

endmodule
